// File: rtl/mips_pkg.sv
// mips_pkg: control-transfer opcode/funct/regimm encodings and 2-bit counter states.
package mips_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [4:0] RI_BLTZ    = 5'h00;
  localparam logic [4:0] RI_BGEZ    = 5'h01;
  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: table of 2-bit saturating counters, one async read port and one training port.
module bht_2bit import mips_pkg::*; #(
  parameter int ENTRIES = 64,
  parameter logic [1:0] INIT_STATE = 2'b01,
  localparam int IDX = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDX-1:0] rd_idx_i,
  output logic [1:0]     rd_cnt_o,
  input  logic           wr_en_i,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic           wr_taken_i
);
  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cur, cnt_d;
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign cur = cnt_q[wr_idx_i];
  always_comb cnt_d = wr_taken_i ? ((cur == ST) ? ST : cur + 2'd1) : ((cur == SNT) ? SNT : cur - 2'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= INIT_STATE;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_d;
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves decode-stage branches/jumps, registers fetch redirect and link,
// and trains the direction predictor.
module branch_resolve_unit import mips_pkg::*; #(
  parameter int BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          if_pc,
  output logic                 if_pred_taken,
  input  logic                 id_valid,
  input  logic                 id_stall,
  input  logic [31:0]          id_pc,
  input  logic                 id_pred_taken,
  input  logic [5:0]           id_opcode,
  input  logic [5:0]           id_funct,
  input  logic [4:0]           id_regimm,
  input  logic [15:0]          id_imm16,
  input  logic [25:0]          id_target26,
  input  logic [31:0]          id_rs_val,
  input  logic [31:0]          id_rt_val,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 link_valid,
  output logic [31:0]          link_value,
  output logic [CNT_WIDTH-1:0] mispredict_count
);
  localparam int IDX = $clog2(BHT_ENTRIES);
  logic is_j, is_jal, is_jr, is_ri, is_beq, is_bne, is_bgtz, is_blez, ri_ge, ri_lt, ri_link;
  logic uncond, is_cti, taken, do_link, acc, redirect_d, redirect_q, link_valid_q;
  logic [2:0] mask;
  logic [31:0] op2, pc4, pc8, target, redirect_pc_q, redirect_pc_d, link_value_q, link_value_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [1:0] rd_cnt;
  logic unused_pc;
  assign unused_pc = ^{if_pc[31:IDX+2], if_pc[1:0], rd_cnt[0]};
  always_comb begin
    is_j    = id_opcode == OP_J;
    is_jal  = id_opcode == OP_JAL;
    is_jr   = id_opcode == OP_SPECIAL && id_funct == FN_JR;
    is_ri   = id_opcode == OP_REGIMM;
    is_beq  = id_opcode == OP_BEQ;
    is_bne  = id_opcode == OP_BNE;
    is_bgtz = id_opcode == OP_BGTZ;
    is_blez = id_opcode == OP_BLEZ;
    ri_ge   = is_ri && (id_regimm == RI_BGEZ || id_regimm == RI_BGEZAL);
    ri_lt   = is_ri && (id_regimm == RI_BLTZ || id_regimm == RI_BLTZAL);
    ri_link = is_ri && (id_regimm == RI_BGEZAL || id_regimm == RI_BLTZAL);
    uncond  = is_j | is_jal | is_jr;
    // mask bits are {gt, eq, lt}: taken when the rs-vs-op2 relation hits any set bit
    mask = uncond ? 3'b111 : is_beq ? 3'b010 : is_bne ? 3'b101 : is_bgtz ? 3'b100 :
           is_blez ? 3'b011 : ri_ge ? 3'b110 : ri_lt ? 3'b001 : 3'b000;
    is_cti  = |mask;
    op2     = (is_ri | is_bgtz | is_blez) ? 32'd0 : id_rt_val;
    taken   = (mask[2] & ($signed(id_rs_val) > $signed(op2))) | (mask[1] & (id_rs_val == op2)) |
              (mask[0] & ($signed(id_rs_val) < $signed(op2)));
    pc4     = id_pc + 32'd4;
    pc8     = id_pc + 32'd8;
    target  = (is_j | is_jal) ? {pc4[31:28], id_target26, 2'b00} : is_jr ? id_rs_val :
              pc4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    do_link = is_jal | ri_link;
    acc     = id_valid & ~id_stall;
    redirect_d    = acc & is_cti & (uncond | (taken != id_pred_taken));
    redirect_pc_d = redirect_d ? (taken ? target : pc8) : redirect_pc_q;
    link_value_d  = (acc & do_link) ? pc8 : link_value_q;
    count_d       = (redirect_d && !(&count_q)) ? count_q + CNT_WIDTH'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      link_valid_q  <= 1'b0;
      redirect_pc_q <= 32'd0;
      link_value_q  <= 32'd0;
      count_q       <= '0;
    end else begin
      redirect_q    <= redirect_d;
      link_valid_q  <= acc & do_link;
      redirect_pc_q <= redirect_pc_d;
      link_value_q  <= link_value_d;
      count_q       <= count_d;
    end
  end
  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign link_valid       = link_valid_q;
  assign link_value       = link_value_q;
  assign mispredict_count = count_q;
  assign if_pred_taken    = rd_cnt[1];
  bht_2bit #(.ENTRIES(BHT_ENTRIES), .INIT_STATE(INIT_STATE)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (if_pc[IDX+1:2]),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (acc & is_cti & ~uncond),
    .wr_idx_i   (id_pc[IDX+1:2]),
    .wr_taken_i (taken)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus with a per-cycle reference model and literal pins.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic if_pred_taken;
  logic id_valid = 1'b0, id_stall = 1'b0, id_pred_taken = 1'b0;
  logic [31:0] id_pc = 32'd0, id_rs_val = 32'd0, id_rt_val = 32'd0;
  logic [5:0] id_opcode = 6'h3f, id_funct = 6'd0;
  logic [4:0] id_regimm = 5'd0;
  logic [15:0] id_imm16 = 16'd0;
  logic [25:0] id_target26 = 26'd0;
  logic redirect, link_valid;
  logic [31:0] redirect_pc, link_value;
  logic [15:0] mispredict_count;
  int n_pass = 0, n_total = 0;

  branch_resolve_unit #(.BHT_ENTRIES(256), .INIT_STATE(2'b01), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_regimm(id_regimm), .id_imm16(id_imm16),
    .id_target26(id_target26), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .redirect(redirect), .redirect_pc(redirect_pc), .link_valid(link_valid),
    .link_value(link_value), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: kind 0 none, 1 J, 2 JAL, 3 JR, 4 branch, 5 branch-and-link
  function automatic int f_kind(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] ri);
    if (op == 6'd2) return 1;
    if (op == 6'd3) return 2;
    if (op == 6'd0) return (fn == 6'd8) ? 3 : 0;
    if (op >= 6'd4 && op <= 6'd7) return 4;
    if (op == 6'd1) return (ri == 5'd0 || ri == 5'd1) ? 4 : (ri == 5'd16 || ri == 5'd17) ? 5 : 0;
    return 0;
  endfunction

  function automatic logic f_taken(input logic [5:0] op, input logic [4:0] ri, input int rs, input int rt);
    case (op)
      6'd4: return rs == rt;
      6'd5: return rs != rt;
      6'd6: return rs <= 0;
      6'd7: return rs > 0;
      6'd1: return (ri == 5'd1 || ri == 5'd17) ? (rs >= 0) : (rs < 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] f_target(input int kind, input logic [31:0] pc, input logic [25:0] t26,
                                           input logic [15:0] imm, input logic [31:0] rs);
    logic [31:0] off;
    off = 32'($signed(imm)) * 32'd4;
    if (kind == 1 || kind == 2) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, t26} * 32'd4);
    if (kind == 3) return rs;
    return pc + 32'd4 + off;
  endfunction

  logic m_red, m_lv;
  logic [31:0] m_rpc, m_lval;
  logic [15:0] m_cnt;
  int bht [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_red <= 1'b0; m_lv <= 1'b0; m_rpc <= 32'd0; m_lval <= 32'd0; m_cnt <= 16'd0;
      for (int i = 0; i < 256; i++) bht[i] <= 1;
    end else begin
      m_red <= 1'b0;
      m_lv <= 1'b0;
      if (id_valid && !id_stall && f_kind(id_opcode, id_funct, id_regimm) != 0) begin
        if (f_kind(id_opcode, id_funct, id_regimm) <= 3 ||
            f_taken(id_opcode, id_regimm, id_rs_val, id_rt_val) != id_pred_taken) begin
          m_red <= 1'b1;
          m_rpc <= f_taken(id_opcode, id_regimm, id_rs_val, id_rt_val) ?
                   f_target(f_kind(id_opcode, id_funct, id_regimm), id_pc, id_target26, id_imm16, id_rs_val) :
                   id_pc + 32'd8;
          if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end
        if (f_kind(id_opcode, id_funct, id_regimm) == 2 || f_kind(id_opcode, id_funct, id_regimm) == 5) begin
          m_lv <= 1'b1;
          m_lval <= id_pc + 32'd8;
        end
        if (f_kind(id_opcode, id_funct, id_regimm) >= 4)
          bht[id_pc[9:2]] <= f_taken(id_opcode, id_regimm, id_rs_val, id_rt_val) ?
                             ((bht[id_pc[9:2]] == 3) ? 3 : bht[id_pc[9:2]] + 1) :
                             ((bht[id_pc[9:2]] == 0) ? 0 : bht[id_pc[9:2]] - 1);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_redirect", {31'd0, redirect}, {31'd0, m_red});
    chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_link_valid", {31'd0, link_valid}, {31'd0, m_lv});
    chk("m_link_value", link_value, m_lval);
    chk("m_count", {16'd0, mispredict_count}, {16'd0, m_cnt});
    chk("m_pred", {31'd0, if_pred_taken}, {31'd0, bht[if_pc[9:2]] >= 2});
  end

  task automatic issue(input logic [31:0] pc, input logic pred, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] ri, input logic [15:0] imm, input logic [25:0] t26,
                       input logic [31:0] rs, input logic [31:0] rt);
    id_pc = pc; id_pred_taken = pred; id_opcode = op; id_funct = fn; id_regimm = ri;
    id_imm16 = imm; id_target26 = t26; id_rs_val = rs; id_rt_val = rt; id_valid = 1'b1;
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    if_pc = 32'h100;
    #1;
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_count", {16'd0, mispredict_count}, 32'd0);
    chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
    idle(1);
    issue(32'h100, 1'b0, 6'd4, 6'd0, 5'd0, 16'h0004, 26'd0, 32'd5, 32'd5);
    chk("beq_redirect", {31'd0, redirect}, 32'd1);
    chk("beq_rpc", redirect_pc, 32'h114);
    chk("beq_count", {16'd0, mispredict_count}, 32'd1);
    chk("beq_pred_trained", {31'd0, if_pred_taken}, 32'd1);
    idle(1);
    chk("beq_pulse_end", {31'd0, redirect}, 32'd0);
    issue(32'h200, 1'b0, 6'd5, 6'd0, 5'd0, 16'h0010, 26'd0, 32'd3, 32'd3);
    chk("bne_redirect", {31'd0, redirect}, 32'd0);
    issue(32'h200, 1'b0, 6'd5, 6'd0, 5'd0, 16'h0010, 26'd0, 32'd3, 32'd3);
    chk("bne2_count", {16'd0, mispredict_count}, 32'd1);
    if_pc = 32'h200;
    issue(32'h200, 1'b0, 6'd4, 6'd0, 5'd0, 16'h0010, 26'd0, 32'd3, 32'd3);
    chk("sat0_then_inc_pred", {31'd0, if_pred_taken}, 32'd0);
    issue(32'h400000, 1'b1, 6'd3, 6'd0, 5'd0, 16'd0, 26'h0000123, 32'd0, 32'd0);
    chk("jal_redirect", {31'd0, redirect}, 32'd1);
    chk("jal_rpc", redirect_pc, 32'h48C);
    chk("jal_link_valid", {31'd0, link_valid}, 32'd1);
    chk("jal_link_value", link_value, 32'h0040_0008);
    issue(32'h300, 1'b1, 6'd1, 6'd0, 5'd16, 16'h0020, 26'd0, 32'hFFFF_FFFF, 32'd7);
    chk("bltzal_redirect", {31'd0, redirect}, 32'd0);
    chk("bltzal_link", link_value, 32'h308);
    issue(32'h500, 1'b1, 6'd7, 6'd0, 5'd0, 16'h0020, 26'd0, 32'h8000_0000, 32'd0);
    chk("bgtz_redirect", {31'd0, redirect}, 32'd1);
    chk("bgtz_rpc", redirect_pc, 32'h508);
    chk("bgtz_count", {16'd0, mispredict_count}, 32'd4);
    idle(1);
    if_pc = 32'h600;
    id_pc = 32'h600; id_pred_taken = 1'b0; id_opcode = 6'd4; id_regimm = 5'd0;
    id_imm16 = 16'hFFFE; id_rs_val = 32'd1; id_rt_val = 32'd1;
    id_valid = 1'b1; id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_no_redirect", {31'd0, redirect}, 32'd0);
    end
    chk("stall_no_train", {31'd0, if_pred_taken}, 32'd0);
    id_stall = 1'b0;
    @(posedge clk); #1;
    id_valid = 1'b0;
    chk("stall_release_redirect", {31'd0, redirect}, 32'd1);
    chk("stall_release_rpc", redirect_pc, 32'h5FC);
    chk("stall_release_count", {16'd0, mispredict_count}, 32'd5);
    chk("stall_release_pred", {31'd0, if_pred_taken}, 32'd1);
    idle(1);
    chk("stall_single_pulse", {31'd0, redirect}, 32'd0);
    if_pc = 32'h100;
    issue(32'h700, 1'b0, 6'd0, 6'd8, 5'd0, 16'd0, 26'd0, 32'h1234, 32'd0);
    chk("jr_redirect", {31'd0, redirect}, 32'd1);
    chk("jr_rpc", redirect_pc, 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_redirect", {31'd0, redirect}, 32'd0);
    chk("arst_rpc", redirect_pc, 32'd0);
    chk("arst_link_value", link_value, 32'd0);
    chk("arst_count", {16'd0, mispredict_count}, 32'd0);
    chk("arst_pred", {31'd0, if_pred_taken}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    issue(32'h100, 1'b0, 6'd4, 6'd0, 5'd0, 16'h0004, 26'd0, 32'd9, 32'd9);
    chk("cold_redirect", {31'd0, redirect}, 32'd1);
    chk("cold_count", {16'd0, mispredict_count}, 32'd1);
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch/jump resolution unit with a direction predictor for the five-stage MIPS pipeline. The decode stage presents a decoded control-transfer instruction with its forwarded operands. The unit classifies the instruction, evaluates the condition, computes the target and link value, and compares the outcome with the fetch-time prediction. It registers a redirect to fetch and trains a table of 2-bit saturating counters.

## Interface
- `BHT_ENTRIES`, 64: number of 2-bit counters; power of two, at least 2.
- `INIT_STATE`, 2'b01: reset value of every counter (weakly not-taken).
- `CNT_WIDTH`, 16: width of the mispredict performance counter.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_pc` in 32: fetch PC; lookup index is `if_pc[IDX+1:2]`, where IDX = log2(BHT_ENTRIES).
- `if_pred_taken` out 1: combinational; counter MSB at the indexed entry.
- `id_valid` in 1: decode holds a valid instruction.
- `id_stall` in 1: decode is stalled; the instruction is not consumed.
- `id_pc` in 32: PC of the instruction in decode.
- `id_pred_taken` in 1: prediction carried from fetch for this instruction.
- `id_opcode`, `id_funct` in 6 each; `id_regimm` in 5: instruction fields.
- `id_imm16` in 16; `id_target26` in 26: instruction fields.
- `id_rs_val`, `id_rt_val` in 32: forwarded operands.
- `redirect` out 1: registered one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc` out 32: corrected next PC.
- `link_valid` out 1; `link_value` out 32: write `link_value` to r31.
- `mispredict_count` out CNT_WIDTH: saturating count of redirects.

## Operation
- Accept condition: `id_valid & ~id_stall`. Nothing changes state when an instruction is not accepted.
- Classify each instruction into masks gt, eq and lt:
  - J, JAL, JR: all three masks set.
  - BEQ: eq. BNE: gt and lt.
  - BGTZ: gt. BLEZ: eq and lt.
  - BGEZ, BGEZAL: gt and eq. BLTZ, BLTZAL: lt.
  - Anything else: not a control transfer (`is_cti` = 0).
- `rt_is_zero` for REGIMM, BGTZ and BLEZ: the second operand is forced to 0.
- Condition evaluation:
  - Compare rs against the second operand as signed 32-bit values.
  - taken = (gt & rs>op2) | (eq & rs==op2) | (lt & rs<op2).
- Targets:
  - J/JAL: {pc4[31:28], target26, 2'b00}.
  - JR: rs.
  - Branches: pc4 + (sign-extend imm16 << 2).
  - pc4 = id_pc+4. All adds are modulo 2^32.
- Fall-through PC is id_pc+8, because of the delay slot.
- Link applies to JAL, BGEZAL and BLTZAL. `link_value` = id_pc+8 and is written whether or not the branch is taken.
- Unconditional jumps (J, JAL, JR):
  - Always redirect to their target, whatever the prediction.
  - Never train the table.
- Conditional branches:
  - Mispredict when taken ≠ `id_pred_taken`.
  - On a mispredict, `redirect_pc` = target if taken, else fall-through.
  - Every accepted conditional branch trains its entry at `id_pc[IDX+1:2]`: increment if taken, decrement if not, saturating at 0 and 3.
- `mispredict_count` increments once per cycle in which `redirect` is asserted, whatever the cause (conditional mispredict or unconditional jump). It saturates at all-ones.

## Timing
- Latency: accepted at edge N, so `redirect`, `redirect_pc`, `link_valid` and `link_value` are valid during cycle N+1.
- `redirect` and `link_valid` are single-cycle pulses, even if the next cycle is a stall.
- `redirect_pc` and `link_value` hold their last value when not pulsing.
- The table updates at edge N.
- Same-cycle lookup and update of one index: `if_pred_taken` returns the pre-update value; the new value is visible from N+1.
- `id_stall` high with `id_valid` high: no outputs pulse, no update, no count. The same instruction is evaluated once, when the stall drops.
- Reset (asynchronous, any time, including mid-redirect):
  - All counters go to `INIT_STATE`.
  - `redirect`, `link_valid`, `redirect_pc`, `link_value` and `mispredict_count` go to 0.
  - The first accepted instruction after release behaves as from a cold start.

## Structure
- A shared package `mips_pkg` holds:
  - Opcode, funct and regimm constants for every instruction listed above.
  - The 2-bit counter constants: SNT=0, WNT=1, WT=2, ST=3.
- One sub-module, `bht_2bit`, contains the counter array:
  - One combinational read port.
  - One write port that applies the saturating increment/decrement.
  - Asynchronous reset to `INIT_STATE`.
- Classification, comparison, target arithmetic and output registers are in the top module.

## Test plan
- Reset, then BEQ at id_pc=0x100 with rs=rt=5, imm16=0x0004, pred=0 -> next cycle: redirect=1, redirect_pc=0x114, count=1; entry 0x40 goes 1→2.
- BNE at 0x200 with rs=rt=3, pred=0 -> no redirect; entry 0x80 saturates at 0 after two decrements from reset.
- JAL at 0x0040_0000 with target26=0x0000123 -> redirect_pc=0x0000048C, link_valid=1, link_value=0x00400008.
- BLTZAL with rs=0xFFFF_FFFF, pred=1 -> no redirect (correctly predicted taken), link_valid=1; BGTZ with rs=0x8000_0000, pred=1 -> redirect to fall-through (negative, so not taken).
- BEQ taken, held with id_stall=1 for 3 cycles -> exactly one redirect pulse and one counter update after the stall releases.
- Assert rst_n=0 in the cycle a redirect is pending -> all outputs 0 immediately; the counter read at `if_pc`=0x100 returns the INIT MSB.
